// File: rtl/calc_pkg.sv
// calc_pkg: key codes, opcode constants and FSM state encoding for the BCD calculator front end
package calc_pkg;
  typedef enum logic [3:0] {
    KEY_DIGIT  = 4'd0,
    KEY_ADD    = 4'd10,
    KEY_SUB    = 4'd11,
    KEY_EQUALS = 4'd12,
    KEY_CLEAR  = 4'd13,
    KEY_SIGN   = 4'd14,
    KEY_NONE   = 4'd15
  } key_code_e;
  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    LOAD_A  = 3'd1,
    ENTER_B = 3'd2,
    LOAD_B  = 3'd3,
    COMPUTE = 3'd4,
    SHOW    = 3'd5
  } entry_state_e;
endpackage

// File: rtl/operand_entry_fsm_if.sv
// operand_entry_fsm_if: keypad inputs plus ALU/display outputs of the operand entry block
//  master: keypad side (drives key_strobe/key_code, observes the rest)
//  slave : operand_entry_fsm side
interface operand_entry_fsm_if;
  logic       key_strobe;
  logic [3:0] key_code;
  logic [8:0] op;
  logic       assign_op1;
  logic       assign_op2;
  logic [2:0] opcode;
  logic       alu_en;
  logic [7:0] entry_digits;
  logic       entry_neg;
  logic [2:0] state_o;
  modport master (output key_strobe, key_code,
                  input  op, assign_op1, assign_op2, opcode, alu_en, entry_digits, entry_neg, state_o);
  modport slave  (input  key_strobe, key_code,
                  output op, assign_op1, assign_op2, opcode, alu_en, entry_digits, entry_neg, state_o);
endinterface

// File: rtl/key_sync_edge.sv
// key_sync_edge: synchronises key_strobe/key_code, detects strobe rising edges, debounces with a holdoff
//  in : clk, nrst (async active-low), key_strobe (async), key_code[3:0] (async)
//  out: key_evt (1-cycle accepted key), key_code_s[3:0] (code captured with the event)
module key_sync_edge #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       key_strobe,
  input  logic [3:0] key_code,
  output logic       key_evt,
  output logic [3:0] key_code_s
);
  localparam int CW = $clog2(HOLDOFF_CYCLES + 1);
  logic [SYNC_STAGES-1:0]      s_q, s_d;
  logic [SYNC_STAGES-1:0][3:0] c_q, c_d;
  logic                        prev_q, prev_d, evt_q, evt_d, hit;
  logic [3:0]                  code_q, code_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  always_comb begin
    s_d    = {s_q[SYNC_STAGES-2:0], key_strobe};
    c_d    = {c_q[SYNC_STAGES-2:0], key_code};
    prev_d = s_q[SYNC_STAGES-1];
    // edges arriving while the holdoff runs are dropped, not deferred
    hit    = s_q[SYNC_STAGES-1] & ~prev_q & (cnt_q == '0);
    evt_d  = hit;
    code_d = hit ? c_q[SYNC_STAGES-1] : code_q;
    cnt_d  = hit ? CW'(HOLDOFF_CYCLES) : (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s_q    <= '0;
      c_q    <= '0;
      prev_q <= 1'b0;
      evt_q  <= 1'b0;
      code_q <= '0;
      cnt_q  <= '0;
    end else begin
      s_q    <= s_d;
      c_q    <= c_d;
      prev_q <= prev_d;
      evt_q  <= evt_d;
      code_q <= code_d;
      cnt_q  <= cnt_d;
    end
  end
  assign key_evt    = evt_q;
  assign key_code_s = code_q;
endmodule

// File: rtl/operand_entry_fsm.sv
// operand_entry_fsm: keypad-to-ALU front end building two signed 2-digit BCD operands and an opcode
//  in : clk, nrst (async active-low), bus.key_strobe, bus.key_code
//  out: bus.op, bus.assign_op1, bus.assign_op2, bus.opcode, bus.alu_en,
//       bus.entry_digits, bus.entry_neg, bus.state_o
//  SIGN_KEY_EN: when defined, key 14 toggles the sign of the operand being typed
module operand_entry_fsm
  import calc_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = 16
) (
  input logic              clk,
  input logic              nrst,
  operand_entry_fsm_if.slave bus
);
  logic         key_evt;
  logic [3:0]   key_code_s;
  entry_state_e state_q, state_d;
  logic [7:0]   buf_q, buf_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         neg_q, neg_d, a1_q, a1_d, a2_q, a2_d, alu_en_q, alu_en_d;
  logic [2:0]   opcode_q, opcode_d;
  logic [8:0]   op_q, op_d;
  logic         digit, addsub, equals, clr, sgn;
  key_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .HOLDOFF_CYCLES(HOLDOFF_CYCLES)) u_sync (
    .clk, .nrst, .key_strobe(bus.key_strobe), .key_code(bus.key_code), .key_evt, .key_code_s
  );
  assign digit  = key_evt && key_code_s < 4'd10;
  assign addsub = key_evt && (key_code_s == KEY_ADD || key_code_s == KEY_SUB);
  assign equals = key_evt && key_code_s == KEY_EQUALS;
  assign clr    = key_evt && key_code_s == KEY_CLEAR;
`ifdef SIGN_KEY_EN
  assign sgn    = key_evt && key_code_s == KEY_SIGN;
`else
  assign sgn    = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    opcode_d = opcode_q;
    alu_en_d = alu_en_q;
    op_d     = '0;
    a1_d     = 1'b0;
    a2_d     = 1'b0;
    case (state_q)
      ENTER_A, ENTER_B: begin
        if (digit && cnt_q < 2'd2) begin
          buf_d = {buf_q[3:0], key_code_s};
          cnt_d = cnt_q + 2'd1;
        end
        if (sgn) neg_d = ~neg_q;
        if (addsub) begin
          opcode_d = key_code_s == KEY_ADD ? OP_ADD : OP_SUB;
          state_d  = state_q == ENTER_A ? LOAD_A : ENTER_B;
        end
        if (equals && state_q == ENTER_B) state_d = LOAD_B;
      end
      LOAD_A: begin
        op_d    = {neg_q, buf_q};
        a1_d    = 1'b1;
        buf_d   = '0;
        cnt_d   = '0;
        neg_d   = 1'b0;
        state_d = ENTER_B;
      end
      LOAD_B: begin
        op_d    = {neg_q, buf_q};
        a2_d    = 1'b1;
        state_d = COMPUTE;
      end
      COMPUTE: begin
        alu_en_d = 1'b1;
        state_d  = SHOW;
      end
      SHOW: if (digit) begin
        alu_en_d = 1'b0;
        opcode_d = OP_NONE;
        buf_d    = {4'h0, key_code_s};
        cnt_d    = 2'd1;
        neg_d    = 1'b0;
        state_d  = ENTER_A;
      end
      default: state_d = ENTER_A;
    endcase
    // CLEAR wins over everything, including a pending operand load
    if (clr) begin
      state_d  = ENTER_A;
      buf_d    = '0;
      cnt_d    = '0;
      neg_d    = 1'b0;
      opcode_d = OP_NONE;
      alu_en_d = 1'b0;
      op_d     = '0;
      a1_d     = 1'b0;
      a2_d     = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ENTER_A;
      buf_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      opcode_q <= OP_NONE;
      alu_en_q <= 1'b0;
      op_q     <= '0;
      a1_q     <= 1'b0;
      a2_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      opcode_q <= opcode_d;
      alu_en_q <= alu_en_d;
      op_q     <= op_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
    end
  end
  assign bus.op           = op_q;
  assign bus.assign_op1   = a1_q;
  assign bus.assign_op2   = a2_q;
  assign bus.opcode       = opcode_q;
  assign bus.alu_en       = alu_en_q;
  assign bus.entry_digits = buf_q;
  assign bus.entry_neg    = neg_q;
  assign bus.state_o      = state_q;
endmodule

// File: tb/tb_operand_entry_fsm.sv
// tb_operand_entry_fsm: directed key-sequence vectors plus bounce and async-reset checks
module tb_operand_entry_fsm;
  import calc_pkg::*;
  typedef struct {
    logic [3:0]   key;
    entry_state_e st;
    logic [7:0]   dig;
    logic [2:0]   opc;
    logic         en;
    int           p;
    logic [8:0]   opv;
  } vec_t;
`ifdef SIGN_KEY_EN
  localparam logic [8:0] SGN_OP = 9'h108;
`else
  localparam logic [8:0] SGN_OP = 9'h008;
`endif
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int total = 0;
  int bad = 0;
  int n_a1, n_a2;
  logic [8:0] op_a1, op_a2;
  vec_t tv [32];
  operand_entry_fsm_if bus ();
  operand_entry_fsm dut (.clk(clk), .nrst(nrst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (bus.assign_op1) begin n_a1++; op_a1 = bus.op; end
    if (bus.assign_op2) begin n_a2++; op_a2 = bus.op; end
    chk("assign_exclusive", {31'd0, bus.assign_op1 & bus.assign_op2}, 32'd0);
    chk("op_idle_zero", (bus.assign_op1 | bus.assign_op2) ? 32'd0 : {23'd0, bus.op}, 32'd0);
  endtask
  task automatic press(input logic [3:0] k);
    bus.key_code = k;
    bus.key_strobe = 1'b1;
    repeat (4) tick();
    bus.key_strobe = 1'b0;
    repeat (22) tick();
  endtask
  task automatic chk_outs(input string tag, input entry_state_e st, input logic [7:0] dig,
                          input logic [2:0] opc, input logic en);
    chk({tag, ".state"}, {29'd0, bus.state_o}, {29'd0, st});
    chk({tag, ".digits"}, {24'd0, bus.entry_digits}, {24'd0, dig});
    chk({tag, ".opcode"}, {29'd0, bus.opcode}, {29'd0, opc});
    chk({tag, ".alu_en"}, {31'd0, bus.alu_en}, {31'd0, en});
  endtask
  initial begin
    logic [0:16] pat;
    tv[0]  = '{4'd4,  ENTER_A, 8'h04, OP_NONE, 1'b0, 0, 9'h000};
    tv[1]  = '{4'd2,  ENTER_A, 8'h42, OP_NONE, 1'b0, 0, 9'h000};
    tv[2]  = '{4'd10, ENTER_B, 8'h00, OP_ADD,  1'b0, 1, 9'h042};
    tv[3]  = '{4'd1,  ENTER_B, 8'h01, OP_ADD,  1'b0, 0, 9'h000};
    tv[4]  = '{4'd7,  ENTER_B, 8'h17, OP_ADD,  1'b0, 0, 9'h000};
    tv[5]  = '{4'd12, SHOW,    8'h17, OP_ADD,  1'b1, 2, 9'h017};
    tv[6]  = '{4'd5,  ENTER_A, 8'h05, OP_NONE, 1'b0, 0, 9'h000};
    tv[7]  = '{4'd11, ENTER_B, 8'h00, OP_SUB,  1'b0, 1, 9'h005};
    tv[8]  = '{4'd3,  ENTER_B, 8'h03, OP_SUB,  1'b0, 0, 9'h000};
    tv[9]  = '{4'd12, SHOW,    8'h03, OP_SUB,  1'b1, 2, 9'h003};
    tv[10] = '{4'd1,  ENTER_A, 8'h01, OP_NONE, 1'b0, 0, 9'h000};
    tv[11] = '{4'd2,  ENTER_A, 8'h12, OP_NONE, 1'b0, 0, 9'h000};
    tv[12] = '{4'd3,  ENTER_A, 8'h12, OP_NONE, 1'b0, 0, 9'h000};
    tv[13] = '{4'd10, ENTER_B, 8'h00, OP_ADD,  1'b0, 1, 9'h012};
    tv[14] = '{4'd13, ENTER_A, 8'h00, OP_NONE, 1'b0, 0, 9'h000};
    tv[15] = '{4'd7,  ENTER_A, 8'h07, OP_NONE, 1'b0, 0, 9'h000};
    tv[16] = '{4'd10, ENTER_B, 8'h00, OP_ADD,  1'b0, 1, 9'h007};
    tv[17] = '{4'd9,  ENTER_B, 8'h09, OP_ADD,  1'b0, 0, 9'h000};
    tv[18] = '{4'd13, ENTER_A, 8'h00, OP_NONE, 1'b0, 0, 9'h000};
    tv[19] = '{4'd8,  ENTER_A, 8'h08, OP_NONE, 1'b0, 0, 9'h000};
    tv[20] = '{4'd14, ENTER_A, 8'h08, OP_NONE, 1'b0, 0, 9'h000};
    tv[21] = '{4'd10, ENTER_B, 8'h00, OP_ADD,  1'b0, 1, SGN_OP};
    tv[22] = '{4'd13, ENTER_A, 8'h00, OP_NONE, 1'b0, 0, 9'h000};
    tv[23] = '{4'd12, ENTER_A, 8'h00, OP_NONE, 1'b0, 0, 9'h000};
    tv[24] = '{4'd15, ENTER_A, 8'h00, OP_NONE, 1'b0, 0, 9'h000};
    tv[25] = '{4'd6,  ENTER_A, 8'h06, OP_NONE, 1'b0, 0, 9'h000};
    tv[26] = '{4'd11, ENTER_B, 8'h00, OP_SUB,  1'b0, 1, 9'h006};
    tv[27] = '{4'd2,  ENTER_B, 8'h02, OP_SUB,  1'b0, 0, 9'h000};
    tv[28] = '{4'd12, SHOW,    8'h02, OP_SUB,  1'b1, 2, 9'h002};
    tv[29] = '{4'd10, SHOW,    8'h02, OP_SUB,  1'b1, 0, 9'h000};
    tv[30] = '{4'd12, SHOW,    8'h02, OP_SUB,  1'b1, 0, 9'h000};
    tv[31] = '{4'd13, ENTER_A, 8'h00, OP_NONE, 1'b0, 0, 9'h000};
    bus.key_strobe = 1'b0;
    bus.key_code = 4'd15;
    n_a1 = 0;
    n_a2 = 0;
    op_a1 = '0;
    op_a2 = '0;
    repeat (3) tick();
    chk_outs("reset", ENTER_A, 8'h00, OP_NONE, 1'b0);
    chk("reset.op", {23'd0, bus.op}, 32'd0);
    nrst = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 32; i++) begin
      n_a1 = 0;
      n_a2 = 0;
      press(tv[i].key);
      chk_outs($sformatf("vec%0d", i), tv[i].st, tv[i].dig, tv[i].opc, tv[i].en);
      chk($sformatf("vec%0d.n_a1", i), n_a1, (tv[i].p == 1) ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d.n_a2", i), n_a2, (tv[i].p == 2) ? 32'd1 : 32'd0);
      if (tv[i].p == 1) chk($sformatf("vec%0d.op1", i), {23'd0, op_a1}, {23'd0, tv[i].opv});
      if (tv[i].p == 2) chk($sformatf("vec%0d.op2", i), {23'd0, op_a2}, {23'd0, tv[i].opv});
    end
    // bounce: rises at offsets 0, 4, 8 give one key; a rise at HOLDOFF_CYCLES+1 is taken
    pat = 17'b11001100110000000;
    bus.key_code = 4'd3;
    for (int n = 0; n < 17; n++) begin
      bus.key_strobe = pat[n];
      tick();
    end
    chk("bounce.first", {24'd0, bus.entry_digits}, 32'h03);
    bus.key_strobe = 1'b1;
    repeat (4) tick();
    bus.key_strobe = 1'b0;
    repeat (22) tick();
    chk("bounce.second", {24'd0, bus.entry_digits}, 32'h33);
    // async reset while showing a result
    press(4'd13);
    press(4'd1);
    press(4'd10);
    press(4'd2);
    press(4'd12);
    chk_outs("pre_rst", SHOW, 8'h02, OP_ADD, 1'b1);
    #2;
    nrst = 1'b0;
    #1;
    chk_outs("async_rst", ENTER_A, 8'h00, OP_NONE, 1'b0);
    chk("async_rst.op", {23'd0, bus.op}, 32'd0);
    chk("async_rst.assign", {30'd0, bus.assign_op1, bus.assign_op2}, 32'd0);
    chk("async_rst.neg", {31'd0, bus.entry_neg}, 32'd0);
    repeat (2) tick();
    nrst = 1'b1;
    press(4'd9);
    chk_outs("post_rst", ENTER_A, 8'h09, OP_NONE, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
